// File: rtl/prog_ctr_pkg.sv
// Shared types for the program counter / fetch sequencer.
package prog_ctr_pkg;
  localparam int PC_W = 10;
  typedef logic [PC_W-1:0] pc_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} pc_state_e;
  localparam pc_t PC_RESET = '0;
endpackage

// File: rtl/prog_ctr_ret_stack.sv
// LIFO return-address stack; a push when full and a pop when empty are dropped.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           wr_idx, top_idx;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign wr_idx  = IW'(cnt);
  assign top_idx = IW'(cnt - CW'(1));
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: entries above cnt are never read.
  always_ff @(posedge Clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end
endmodule

// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer with Start/Done handshake.
// Optional return stack enabled by defining PROG_CTR_RET_STACK_EN.
module prog_ctr
  import prog_ctr_pkg::*;
#(
  parameter int D        = PC_W,
  parameter int RS_DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Stall,
  input  logic         Halt,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic         Taken,
  input  logic [3:0]   LutIdx,
  output logic [3:0]   LutAddr,
  input  logic [D-1:0] LutTarget,
  input  logic         Call,
  input  logic         Ret,
  output logic [D-1:0] ProgCtr,
  output logic         Running,
  output logic         Done,
  output logic         Wrap,
  output logic         StackErr
);
  pc_state_e    state, state_nx;
  logic [D-1:0] pc_nx, pc_inc;
  logic         done_nx, wrap_nx;
  logic         call_req, ret_req, push, pop, err_set, err_clr;
  logic         stk_full, stk_empty;
  logic [D-1:0] stk_dout;

  assign LutAddr = LutIdx;
  assign Running = (state == RUN);
  assign pc_inc  = ProgCtr + D'(1);

`ifdef PROG_CTR_RET_STACK_EN
  assign call_req = Call;
  assign ret_req  = Ret;

  ret_stack #(.DEPTH(RS_DEPTH), .W(D)) u_ret_stack (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .push   (push),
    .pop    (pop),
    .din    (pc_inc),
    .dout   (stk_dout),
    .full   (stk_full),
    .empty  (stk_empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)     StackErr <= 1'b0;
    else if (err_clr) StackErr <= 1'b0;
    else if (err_set) StackErr <= 1'b1;
  end
`else
  logic unused_ok;
  assign call_req  = 1'b0;
  assign ret_req   = 1'b0;
  assign stk_full  = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_dout  = '0;
  assign StackErr  = 1'b0;
  assign unused_ok = ^{Call, Ret, push, pop, err_set, err_clr};
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = ProgCtr;
    done_nx  = Done;
    wrap_nx  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nx = RUN;
          pc_nx    = D'(PC_RESET);
        end
      end
      HALT: begin
        if (Start) begin
          state_nx = RUN;
          pc_nx    = D'(PC_RESET);
          done_nx  = 1'b0;
          err_clr  = 1'b1;
        end
      end
      RUN: begin
        if (!Stall) begin
          if (Halt) begin
            state_nx = HALT;
            done_nx  = 1'b1;
          end else if (call_req) begin
            // A full stack loses the return address but the jump still happens.
            push    = !stk_full;
            err_set = stk_full;
            pc_nx   = LutTarget;
          end else if (ret_req) begin
            if (stk_empty) begin
              err_set = 1'b1;
              pc_nx   = pc_inc;
            end else begin
              pop   = 1'b1;
              pc_nx = stk_dout;
            end
          end else if (BranchEn && Taken) begin
            pc_nx = BranchRel ? (ProgCtr + LutTarget) : LutTarget;
          end else begin
            pc_nx   = pc_inc;
            wrap_nx = &ProgCtr;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      ProgCtr <= D'(PC_RESET);
      Done    <= 1'b0;
      Wrap    <= 1'b0;
    end else begin
      state   <= state_nx;
      ProgCtr <= pc_nx;
      Done    <= done_nx;
      Wrap    <= wrap_nx;
    end
  end
endmodule

// File: tb/tb_prog_ctr.sv
// Randomized and directed bench for prog_ctr with a PC-level reference model.
module tb_prog_ctr;
  localparam int D  = 10;
  localparam int RS = 4;
  localparam int M  = 1 << D;

  logic         Clk = 1'b0;
  logic         Reset_n, Start, Stall, Halt, BranchEn, BranchRel, Taken, Call, Ret;
  logic [3:0]   LutIdx, LutAddr;
  logic [D-1:0] LutTarget, ProgCtr;
  logic         Running, Done, Wrap, StackErr;

  prog_ctr #(.D(D), .RS_DEPTH(RS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .BranchRel(BranchRel), .Taken(Taken), .LutIdx(LutIdx),
    .LutAddr(LutAddr), .LutTarget(LutTarget), .Call(Call), .Ret(Ret),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .Wrap(Wrap), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 run, 2 halted.
  int m_st, m_pc;
  bit m_done, m_wrap, m_err;
  int stk[$];
`ifdef PROG_CTR_RET_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  task automatic clr_in();
    Start = 0; Stall = 0; Halt = 0; BranchEn = 0; BranchRel = 0; Taken = 0;
    Call = 0; Ret = 0; LutIdx = '0; LutTarget = '0;
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_done = 0; m_wrap = 0; m_err = 0; stk.delete();
  endtask

  task automatic cycle();
    m_wrap = 0;
    if (m_st == 0) begin
      if (Start) begin m_st = 1; m_pc = 0; end
    end else if (m_st == 2) begin
      if (Start) begin m_st = 1; m_pc = 0; m_done = 0; m_err = 0; end
    end else if (!Stall) begin
      if (Halt) begin
        m_st = 2; m_done = 1;
      end else if (STACK_EN && Call) begin
        if (stk.size() < RS) stk.push_back((m_pc + 1) % M);
        else m_err = 1;
        m_pc = int'(LutTarget);
      end else if (STACK_EN && Ret) begin
        if (stk.size() > 0) m_pc = stk.pop_back();
        else begin m_err = 1; m_pc = (m_pc + 1) % M; end
      end else if (BranchEn && Taken) begin
        m_pc = BranchRel ? (m_pc + int'(LutTarget)) % M : int'(LutTarget);
      end else begin
        if (m_pc == M - 1) m_wrap = 1;
        m_pc = (m_pc + 1) % M;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 0; clr_in(); model_reset();
    #2;
    checks++;
    if (ProgCtr !== '0 || Running !== 0 || Done !== 0 || Wrap !== 0 || StackErr !== 0) begin
      errors++; $display("FAIL reset_init: pc=%0d run=%b done=%b wrap=%b err=%b want all 0",
                         ProgCtr, Running, Done, Wrap, StackErr);
    end
    @(negedge Clk); Reset_n = 1;
    Start = 1; cycle(); Start = 0;
    repeat (37) cycle();
    checks++;
    if (ProgCtr !== D'(37) || Running !== 1) begin
      errors++; $display("FAIL reset_pre: pc=%0d run=%b want 37 1", ProgCtr, Running);
    end
    #2 Reset_n = 0;
    #1;
    model_reset();
    checks++;
    if (ProgCtr !== '0 || Running !== 0 || Done !== 0) begin
      errors++; $display("FAIL reset_async: pc=%0d run=%b done=%b want 0 0 0", ProgCtr, Running, Done);
    end
    @(negedge Clk); Reset_n = 1;
  endtask

  task automatic test_sequence();
    clr_in();
    Start = 1; cycle(); Start = 0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) cycle();
      checks++;
      if (ProgCtr !== D'(i) || Running !== 1 || Done !== 0) begin
        errors++; $display("FAIL seq_pc: step %0d pc=%0d run=%b done=%b want %0d 1 0",
                           i, ProgCtr, Running, Done, i);
      end
    end
    Halt = 1; cycle(); Halt = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ProgCtr !== D'(5) || Done !== 1 || Running !== 0) begin
        errors++; $display("FAIL seq_halt: cyc %0d pc=%0d done=%b run=%b want 5 1 0",
                           i, ProgCtr, Done, Running);
      end
      BranchEn = 1; Taken = 1; LutTarget = D'(77);
      cycle();
      clr_in();
    end
    Start = 1; cycle(); Start = 0;
    checks++;
    if (ProgCtr !== '0 || Done !== 0 || Running !== 1) begin
      errors++; $display("FAIL seq_restart: pc=%0d done=%b run=%b want 0 0 1", ProgCtr, Done, Running);
    end
  endtask

  task automatic test_branch();
    clr_in();
    repeat (4) cycle();
    checks++;
    if (ProgCtr !== D'(4)) begin
      errors++; $display("FAIL br_setup: pc=%0d want 4", ProgCtr);
    end
    BranchEn = 1; Taken = 1; BranchRel = 1; LutTarget = 10'h3FF; cycle();
    checks++;
    if (ProgCtr !== D'(3)) begin
      errors++; $display("FAIL br_rel_neg: pc=%0d want 3", ProgCtr);
    end
    BranchRel = 0; LutTarget = D'(4); cycle();
    LutTarget = D'(20); cycle();
    checks++;
    if (ProgCtr !== D'(20)) begin
      errors++; $display("FAIL br_abs: pc=%0d want 20", ProgCtr);
    end
    LutTarget = D'(4); cycle();
    Taken = 0; LutTarget = D'(300); cycle();
    checks++;
    if (ProgCtr !== D'(5)) begin
      errors++; $display("FAIL br_not_taken: pc=%0d want 5", ProgCtr);
    end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] idx;
      idx = 4'($urandom_range(0, 15));
      LutIdx = idx;
      #1;
      checks++;
      if (LutAddr !== idx) begin
        errors++; $display("FAIL lut_addr: got %0h want %0h", LutAddr, idx);
      end
    end
    clr_in();
  endtask

  task automatic test_wrap();
    clr_in();
    BranchEn = 1; Taken = 1; LutTarget = D'(1020); cycle(); clr_in();
    repeat (3) cycle();
    checks++;
    if (ProgCtr !== D'(1023) || Wrap !== 0) begin
      errors++; $display("FAIL wrap_pre: pc=%0d wrap=%b want 1023 0", ProgCtr, Wrap);
    end
    cycle();
    checks++;
    if (ProgCtr !== '0 || Wrap !== 1) begin
      errors++; $display("FAIL wrap_pulse: pc=%0d wrap=%b want 0 1", ProgCtr, Wrap);
    end
    cycle();
    checks++;
    if (ProgCtr !== D'(1) || Wrap !== 0) begin
      errors++; $display("FAIL wrap_clear: pc=%0d wrap=%b want 1 0", ProgCtr, Wrap);
    end
    BranchEn = 1; Taken = 1; LutTarget = D'(1020); cycle();
    BranchRel = 1; LutTarget = D'(10); cycle(); clr_in();
    checks++;
    if (ProgCtr !== D'(6) || Wrap !== 0) begin
      errors++; $display("FAIL wrap_rel: pc=%0d wrap=%b want 6 0", ProgCtr, Wrap);
    end
  endtask

  task automatic test_stall();
    clr_in();
    BranchEn = 1; Taken = 1; LutTarget = D'(8); cycle();
    LutTarget = D'(100); Stall = 1; Halt = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (ProgCtr !== D'(8) || Running !== 1 || Wrap !== 0) begin
        errors++; $display("FAIL stall_hold: cyc %0d pc=%0d run=%b want 8 1", i, ProgCtr, Running);
      end
    end
    Stall = 0; Halt = 0; cycle(); clr_in();
    checks++;
    if (ProgCtr !== D'(100)) begin
      errors++; $display("FAIL stall_release: pc=%0d want 100", ProgCtr);
    end
  endtask

`ifdef PROG_CTR_RET_STACK_EN
  task automatic test_stack();
    int tgt[5] = '{200, 300, 400, 500, 600};
    int exp_ret[4] = '{401, 301, 201, 101};
    clr_in();
    for (int i = 0; i < 5; i++) begin
      Call = 1; LutTarget = D'(tgt[i]); cycle();
      checks++;
      if (ProgCtr !== D'(tgt[i]) || StackErr !== (i == 4)) begin
        errors++; $display("FAIL stk_call: %0d pc=%0d err=%b want %0d %0d",
                           i, ProgCtr, StackErr, tgt[i], i == 4);
      end
    end
    Call = 0;
    for (int i = 0; i < 4; i++) begin
      Ret = 1; cycle();
      checks++;
      if (ProgCtr !== D'(exp_ret[i])) begin
        errors++; $display("FAIL stk_ret: %0d pc=%0d want %0d", i, ProgCtr, exp_ret[i]);
      end
    end
    cycle(); clr_in();
    checks++;
    if (ProgCtr !== D'(102) || StackErr !== 1) begin
      errors++; $display("FAIL stk_underflow: pc=%0d err=%b want 102 1", ProgCtr, StackErr);
    end
    Call = 1; Ret = 1; LutTarget = D'(50); cycle(); clr_in();
    checks++;
    if (ProgCtr !== D'(50)) begin
      errors++; $display("FAIL stk_call_ret: pc=%0d want 50", ProgCtr);
    end
    Halt = 1; cycle(); Halt = 0; Start = 1; cycle(); Start = 0;
    checks++;
    if (StackErr !== 0 || ProgCtr !== '0) begin
      errors++; $display("FAIL stk_restart: err=%b pc=%0d want 0 0", StackErr, ProgCtr);
    end
  endtask
`endif

  task automatic test_random();
    clr_in();
    for (int n = 0; n < 600; n++) begin
      Start     = ($urandom_range(0, 99) < 5);
      Halt      = ($urandom_range(0, 99) < 3);
      Stall     = ($urandom_range(0, 99) < 15);
      BranchEn  = ($urandom_range(0, 99) < 30);
      Taken     = 1'($urandom);
      BranchRel = 1'($urandom);
      Call      = ($urandom_range(0, 99) < 8);
      Ret       = ($urandom_range(0, 99) < 8);
      LutIdx    = 4'($urandom);
      LutTarget = D'($urandom);
      cycle();
      checks++;
      if (ProgCtr !== D'(m_pc) || Running !== (m_st == 1) || Done !== m_done ||
          Wrap !== m_wrap || StackErr !== m_err) begin
        errors++;
        $display("FAIL rand %0d: pc=%0d run=%b done=%b wrap=%b err=%b want %0d %b %b %b %b",
                 n, ProgCtr, Running, Done, Wrap, StackErr,
                 m_pc, m_st == 1, m_done, m_wrap, m_err);
      end
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_branch();
    test_wrap();
    test_stall();
`ifdef PROG_CTR_RET_STACK_EN
    test_stack();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
